store_queue: RTL
================

Name: store_queue

Overview:
- Parametrised store queue for the memory stage; successor to the single-word store buffer.
- Holds up to DEPTH speculative or committed stores with byte granularity (SB/SH/SW).
- Forwards to same-cycle loads byte-by-byte, youngest entry wins, and flags partial-coverage conflicts.
- Drains committed entries in order to the dcache through a valid/ready write port.

Parameters:
- DEPTH, 4: number of entries; power of two, >= 2.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte lanes NB = DATA_W/8.
- IDX_W, $clog2(DEPTH): entry index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  store allocation request.
- req_ready_o  out  1  entry available for allocation.
- req_addr_i  in  ADDR_W  store byte address.
- req_data_i  in  DATA_W  store data, LSB-justified.
- req_size_i  in  2  0=byte, 1=half, 2=word; 3 is illegal and treated as misaligned.
- req_idx_o  out  IDX_W  index allocated; meaningful when req_valid_i && req_ready_o.
- req_misalign_o  out  1  current request is misaligned or illegal; no entry allocated.
- commit_valid_i  in  1  commit one entry.
- commit_idx_i  in  IDX_W  entry to commit.
- discard_i  in  DEPTH  mask of speculative entries to squash.
- ld_valid_i  in  1  load lookup.
- ld_addr_i  in  ADDR_W  load byte address.
- ld_size_i  in  2  load size, same encoding as req_size_i.
- ld_hit_o  out  1  every requested byte is covered by the queue.
- ld_conflict_o  out  1  some, but not all, requested bytes are covered.
- ld_data_o  out  DATA_W  merged data, lane-aligned to the word.
- dc_valid_o  out  1  head entry ready to write to the dcache.
- dc_ready_i  in  1  dcache accepts the write.
- dc_addr_o  out  ADDR_W  word-aligned address (low log2(NB) bits zero).
- dc_data_o  out  DATA_W  lane-aligned write data.
- dc_be_o  out  NB  byte enables.
- count_o  out  IDX_W+1  number of occupied entries.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.

Behaviour:
- Reset (async, rst_i=1):
  - All entries FREE; head = tail = 0.
  - count_o = 0, empty_o = 1, full_o = 0.
  - dc_valid_o, ld_hit_o, ld_conflict_o, req_misalign_o = 0.
  - All data/address outputs = 0.
  - Reset asserted mid-drain drops every entry, including committed entries not yet written.
- Entry states: FREE -> SPEC (allocate) -> COMMITTED (commit) -> FREE (drained). SPEC -> FREE on discard.
- Circular buffer: allocation at tail, drain from head; pointers wrap modulo DEPTH.
- Alignment:
  - Byte lane offset = addr[log2(NB)-1:0].
  - Half requires offset bit0 = 0; word requires offset = 0.
  - On violation: req_misalign_o = 1 combinationally and no allocation occurs.
- Allocation:
  - req_ready_o = !full_o && (discard_i == 0).
  - On req_valid_i && req_ready_o && !req_misalign_o:
    - entry[tail] <= SPEC with word address, data shifted into its lanes, and byte enables;
    - req_idx_o = tail (combinational);
    - tail advances next cycle.
  - No same-cycle reuse of an entry freed by drain.
- Commit: commit_valid_i with a SPEC entry -> COMMITTED next cycle. Commit to a FREE or COMMITTED entry is ignored. Commits may arrive out of order.
- Discard:
  - Each SPEC entry with its mask bit set -> FREE next cycle; COMMITTED entries ignore the mask.
  - The mask is always a contiguous youngest run. Tail rewinds to the oldest squashed index and count_o decreases accordingly.
  - Discard and commit on the same index in the same cycle: discard wins.
- Drain:
  - dc_valid_o = (entry[head] == COMMITTED).
  - dc_* outputs come directly from head registers and are stable while dc_valid_o && !dc_ready_i.
  - On handshake: head is freed and advances next cycle. Throughput is 1 store/cycle.
  - A SPEC head blocks drain even if younger entries are committed.
- Forwarding (combinational, all non-FREE entries):
  - For each requested lane, the youngest entry (closest to tail) with matching word address and that lane enabled supplies the byte.
  - ld_hit_o = ld_valid_i && all lanes covered.
  - ld_conflict_o = ld_valid_i && at least one lane covered && not all lanes covered.
  - Uncovered lanes of ld_data_o = 0. No sign extension is done here.
  - An entry draining in the same cycle still forwards.
  - A store allocated in the same cycle does not forward.
- count_o next = count + alloc - drain - discarded.
- Simultaneous alloc + drain keeps count unchanged.

Test Plan:
- Reset, then SW 0x1000=0xAABBCCDD (idx 0), commit 0, dc_ready=1 -> dc_valid 1 cycle later with addr 0x1000, data 0xAABBCCDD, be 0xF; empty_o=1 afterwards.
- SW 0x2000=0x11223344, then SB 0x2001=0x55, load LW 0x2000 -> ld_hit_o=1, ld_data_o=0x11225544; load LW 0x2004 -> hit=0, conflict=0.
- SH 0x3002=0xBEEF only, load LW 0x3000 -> ld_conflict_o=1, ld_hit_o=0; LH 0x3002 -> hit=1, data=0xBEEF0000.
- Fill DEPTH=4 entries -> full_o=1, req_ready_o=0; commit idx 2 only -> dc_valid_o stays 0 (head SPEC); discard mask 4'b1000 -> count_o=3, tail=3.
- SH 0x4001 -> req_misalign_o=1, count unchanged; dc_ready_i low 3 cycles on committed head -> dc_* stable, pops on 4th cycle.
- Assert rst_i mid-drain with 2 committed entries -> dc_valid_o=0 immediately, count_o=0, empty_o=1.

Source files
------------

// File: rtl/store_queue.sv
// Store queue for the memory stage: a circular buffer of byte-granular stores.
// Stores are allocated speculatively, then committed or squashed. Loads see
// store data forwarded lane by lane, with the youngest store winning.
// Committed entries drain in order to the dcache over a valid/ready port.
module store_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic [1:0]        req_size_i,
    output logic [IDX_W-1:0]  req_idx_o,
    output logic              req_misalign_o,
    input  logic              commit_valid_i,
    input  logic [IDX_W-1:0]  commit_idx_i,
    input  logic [DEPTH-1:0]  discard_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [1:0]        ld_size_i,
    output logic              ld_hit_o,
    output logic              ld_conflict_o,
    output logic [DATA_W-1:0] ld_data_o,
    output logic              dc_valid_o,
    input  logic              dc_ready_i,
    output logic [ADDR_W-1:0] dc_addr_o,
    output logic [DATA_W-1:0] dc_data_o,
    output logic [DATA_W/8-1:0] dc_be_o,
    output logic [IDX_W:0]    count_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_SPEC   = 2'd1,
        ST_COMMIT = 2'd2
    } ent_state_e;

    // Byte lanes touched by an access of the given size at the given lane offset.
    function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic [NB-1:0] base;
        case (size)
            2'd0:    base = NB'(32'd1);
            2'd1:    base = NB'(32'd3);
            2'd2:    base = NB'(32'd15);
            default: base = '0;
        endcase
        return base << off;
    endfunction

    // Size 3 is illegal and folds into the misaligned case.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = off[0];
            2'd2:    mis = (off != '0);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Expand byte enables into a per-bit mask.
    function automatic logic [DATA_W-1:0] be_to_bits(input logic [NB-1:0] be);
        logic [DATA_W-1:0] bits;
        bits = '0;
        for (int b = 0; b < NB; b++) begin
            bits[8*b +: 8] = {8{be[b]}};
        end
        return bits;
    endfunction

    ent_state_e        st_r   [DEPTH];
    ent_state_e        st_n_s [DEPTH];
    logic [ADDR_W-1:0] addr_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];
    logic [NB-1:0]     be_r   [DEPTH];
    logic [IDX_W-1:0]  head_r;
    logic [IDX_W-1:0]  tail_r;
    logic [IDX_W:0]    count_r;

    logic [IDX_W-1:0]  head_n_s;
    logic [IDX_W-1:0]  tail_n_s;
    logic [IDX_W:0]    count_n_s;
    logic [IDX_W:0]    disc_cnt_s;
    logic [OFF_W-1:0]  req_off_s;
    logic              req_mis_s;
    logic [NB-1:0]     req_be_s;
    logic              full_s;
    logic              alloc_s;
    logic              dc_fire_s;
    logic [NB-1:0]     ld_mask_s;
    logic [ADDR_W-1:0] ld_word_s;
    logic [NB-1:0]     fwd_cov_s;
    logic [DATA_W-1:0] fwd_data_s;
    logic              ld_all_s;
    logic              ld_any_s;

    assign req_off_s      = req_addr_i[OFF_W-1:0];
    assign req_mis_s      = is_misaligned(req_size_i, req_off_s);
    assign req_be_s       = lane_mask(req_size_i, req_off_s);
    assign full_s         = (count_r == (IDX_W+1)'(DEPTH));
    // Allocation stalls while a squash rewinds the tail.
    assign req_ready_o    = !full_s && (discard_i == '0);
    assign req_misalign_o = !rst_i && req_valid_i && req_mis_s;
    assign alloc_s        = req_valid_i && req_ready_o && !req_mis_s;
    assign req_idx_o      = tail_r;

    assign dc_valid_o     = (st_r[head_r] == ST_COMMIT);
    assign dc_fire_s      = dc_valid_o && dc_ready_i;
    assign dc_addr_o      = addr_r[head_r];
    assign dc_data_o      = data_r[head_r];
    assign dc_be_o        = be_r[head_r];

    assign count_o        = count_r;
    assign empty_o        = (count_r == '0);
    assign full_o         = full_s;

    // Per-entry lifecycle and pointer/occupancy bookkeeping.
    always_comb begin
        disc_cnt_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            st_n_s[i] = st_r[i];
            case (st_r[i])
                ST_FREE: begin
                    st_n_s[i] = (alloc_s && (tail_r == IDX_W'(i))) ? ST_SPEC : ST_FREE;
                end
                ST_SPEC: begin
                    if (discard_i[i]) begin
                        st_n_s[i]  = ST_FREE;
                        disc_cnt_s = disc_cnt_s + (IDX_W+1)'(1'b1);
                    end else if (commit_valid_i && (commit_idx_i == IDX_W'(i))) begin
                        st_n_s[i] = ST_COMMIT;
                    end else begin
                        st_n_s[i] = ST_SPEC;
                    end
                end
                ST_COMMIT: begin
                    st_n_s[i] = (dc_fire_s && (head_r == IDX_W'(i))) ? ST_FREE : ST_COMMIT;
                end
                default: begin
                    st_n_s[i] = ST_FREE;
                end
            endcase
        end
        // Squashed entries are always the youngest run, so the tail simply steps back.
        head_n_s  = head_r + IDX_W'(dc_fire_s);
        tail_n_s  = tail_r + IDX_W'(alloc_s) - disc_cnt_s[IDX_W-1:0];
        count_n_s = count_r + (IDX_W+1)'(alloc_s) - (IDX_W+1)'(dc_fire_s) - disc_cnt_s;
    end

    // Entry states, pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_r[i] <= ST_FREE;
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                st_r[i] <= st_n_s[i];
            end
            head_r  <= head_n_s;
            tail_r  <= tail_n_s;
            count_r <= count_n_s;
        end
    end

    // Store payload: word address, lane-aligned data (disabled lanes zeroed), enables.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= '0;
                data_r[i] <= '0;
                be_r[i]   <= '0;
            end
        end else if (alloc_s) begin
            addr_r[tail_r] <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            data_r[tail_r] <= (req_data_i << {req_off_s, 3'b000}) & be_to_bits(req_be_s);
            be_r[tail_r]   <= req_be_s;
        end
    end

    assign ld_mask_s = lane_mask(ld_size_i, ld_addr_i[OFF_W-1:0]);
    assign ld_word_s = {ld_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Forwarding: walk oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        logic [IDX_W-1:0] ix;
        logic             match;
        logic             take;
        ix         = '0;
        match      = 1'b0;
        take       = 1'b0;
        fwd_cov_s  = '0;
        fwd_data_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ix    = head_r + IDX_W'(k);
            match = (st_r[ix] != ST_FREE) && (addr_r[ix] == ld_word_s);
            for (int b = 0; b < NB; b++) begin
                take                 = match && be_r[ix][b] && ld_mask_s[b];
                fwd_cov_s[b]         = fwd_cov_s[b] | take;
                fwd_data_s[8*b +: 8] = take ? data_r[ix][8*b +: 8] : fwd_data_s[8*b +: 8];
            end
        end
    end

    assign ld_all_s      = (ld_mask_s != '0) && ((fwd_cov_s & ld_mask_s) == ld_mask_s);
    assign ld_any_s      = (fwd_cov_s != '0);
    assign ld_hit_o      = ld_valid_i && ld_all_s;
    assign ld_conflict_o = ld_valid_i && ld_any_s && !ld_all_s;
    assign ld_data_o     = ld_valid_i ? fwd_data_s : '0;

endmodule
